// File: rtl/wvb_occupancy_ctrl_pkg.sv
// Shared definitions for the waveform-buffer occupancy/overflow controller:
// FSM encoding, occupancy width and header-bundle field positions.
package wvb_occupancy_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_OVF     = 2'd2,
    ST_RECOVER = 2'd3
  } ovf_state_e;

  localparam int WVB_WUSED_W = 16;

  // stop_addr location inside the event header bundle (extracted upstream)
  localparam int HDR_STOP_ADDR_LSB = 0;
  localparam int HDR_STOP_ADDR_W   = 12;

endpackage

// File: rtl/wvb_occupancy_ctrl_if.sv
// Write/readout handshake between the wvb write controller, the readout path
// and the occupancy controller; overflow is the inhibit back to the writer.
interface wvb_occupancy_ctrl_if #(
  parameter int P_ADR_WIDTH = 12
);
  logic [P_ADR_WIDTH-1:0] wvb_wr_addr;
  logic                   wvb_wr_en;
  logic                   wvb_rddone;
  logic [P_ADR_WIDTH-1:0] rd_stop_addr;
  logic                   hdr_full;
  logic                   overflow;

  modport master (
    output wvb_wr_addr, wvb_wr_en, wvb_rddone, rd_stop_addr, hdr_full,
    input  overflow
  );

  modport slave (
    input  wvb_wr_addr, wvb_wr_en, wvb_rddone, rd_stop_addr, hdr_full,
    output overflow
  );
endinterface

// File: rtl/wvb_occupancy_ctrl_hyst_flag.sv
// Generic hysteresis flag: set at val >= set_th, clear at val <= clr_th,
// otherwise hold. Set wins when both thresholds are met.
module wvb_occupancy_ctrl_hyst_flag #(
  parameter int P_VAL_WIDTH = 16,
  parameter int P_TH_WIDTH  = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [P_VAL_WIDTH-1:0] val,
  input  logic [P_TH_WIDTH-1:0]  set_th,
  input  logic [P_TH_WIDTH-1:0]  clr_th,
  output logic                   flag
);

  localparam int CW = (P_VAL_WIDTH > P_TH_WIDTH) ? P_VAL_WIDTH : P_TH_WIDTH;

  logic [CW-1:0] val_ext;
  logic [CW-1:0] set_ext;
  logic [CW-1:0] clr_ext;

  assign val_ext = CW'(val);
  assign set_ext = CW'(set_th);
  assign clr_ext = CW'(clr_th);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag <= 1'b0;
    end else if (val_ext >= set_ext) begin
      flag <= 1'b1;
    end else if (val_ext <= clr_ext) begin
      flag <= 1'b0;
    end
  end

endmodule

// File: rtl/wvb_occupancy_ctrl.sv
// Waveform-buffer occupancy tracker and delayed, recoverable overflow
// controller with watermark hysteresis, sticky status and event counter.
module wvb_occupancy_ctrl
  import wvb_occupancy_ctrl_pkg::*;
#(
  parameter int P_ADR_WIDTH   = 12,
  parameter int P_WUSED_WIDTH = WVB_WUSED_W,
  parameter int P_OVF_DELAY   = 2,
  parameter int P_CNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  wvb_occupancy_ctrl_if.slave      bus,
  input  logic [P_ADR_WIDTH:0]     hwm_thresh,
  input  logic [P_ADR_WIDTH:0]     lwm_thresh,
  input  logic                     ovf_clr,
  output logic                     overflow_sticky,
  output logic                     almost_full,
  output logic [P_WUSED_WIDTH-1:0] wvb_wused,
  output logic [P_CNT_WIDTH-1:0]   ovf_count
);

  localparam int DCNT_W = (P_OVF_DELAY < 2) ? 1 : $clog2(P_OVF_DELAY + 1);
  localparam logic [P_WUSED_WIDTH-1:0] WUSED_FULL = P_WUSED_WIDTH'(1) << P_ADR_WIDTH;

  function automatic logic [P_CNT_WIDTH-1:0] sat_inc(input logic [P_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + P_CNT_WIDTH'(1);
  endfunction

  logic [P_ADR_WIDTH-1:0]   rd_ptr;
  logic [P_ADR_WIDTH-1:0]   wr_addr_inc;
  logic [P_ADR_WIDTH-1:0]   occ_diff;
  logic [P_WUSED_WIDTH-1:0] lwm_ext;
  logic                     full;
  logic                     fill_wr;

  ovf_state_e               state;
  ovf_state_e               state_nxt;
  logic [DCNT_W-1:0]        dcnt;
  logic [DCNT_W-1:0]        dcnt_nxt;
  logic                     ovf_entry;
  logic                     buf_ovf;

  assign wr_addr_inc = bus.wvb_wr_addr + P_ADR_WIDTH'(1);
  // Writes while already full are ignored, so only a non-full write can fill.
  assign fill_wr     = bus.wvb_wr_en && !full && (wr_addr_inc == rd_ptr);
  assign occ_diff    = bus.wvb_wr_addr - rd_ptr;
  assign lwm_ext     = P_WUSED_WIDTH'(lwm_thresh);

  // Pointer, full flag and occupancy stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      full      <= 1'b0;
      wvb_wused <= '0;
    end else begin
      if (bus.wvb_rddone) begin
        rd_ptr <= bus.rd_stop_addr + P_ADR_WIDTH'(1);
      end
      if (bus.wvb_rddone) begin
        full <= 1'b0;
      end else if (fill_wr) begin
        full <= 1'b1;
      end
      wvb_wused <= full ? WUSED_FULL : P_WUSED_WIDTH'(occ_diff);
    end
  end

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    ovf_entry = 1'b0;
    case (state)
      ST_IDLE: begin
        if (full) begin
          state_nxt = ST_DELAY;
          dcnt_nxt  = DCNT_W'(1);
        end
      end
      ST_DELAY: begin
        if (!full) begin
          state_nxt = ST_IDLE;
          dcnt_nxt  = '0;
        end else if (dcnt == DCNT_W'(P_OVF_DELAY)) begin
          state_nxt = ST_OVF;
          dcnt_nxt  = '0;
          ovf_entry = 1'b1;
        end else begin
          dcnt_nxt = dcnt + DCNT_W'(1);
        end
      end
      ST_OVF: begin
        if (!full) begin
          state_nxt = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        if (full) begin
          state_nxt = ST_OVF;
        end else if (wvb_wused <= lwm_ext) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        dcnt_nxt  = '0;
      end
    endcase
  end

  // Overflow control stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      dcnt            <= '0;
      buf_ovf         <= 1'b0;
      overflow_sticky <= 1'b0;
      ovf_count       <= '0;
    end else begin
      state   <= state_nxt;
      dcnt    <= dcnt_nxt;
      buf_ovf <= (state_nxt == ST_OVF) || (state_nxt == ST_RECOVER);
      if (ovf_entry) begin
        overflow_sticky <= 1'b1;
      end else if (ovf_clr) begin
        overflow_sticky <= 1'b0;
      end
      if (ovf_entry) begin
        ovf_count <= sat_inc(ovf_count);
      end
    end
  end

  assign bus.overflow = bus.hdr_full | buf_ovf;

  wvb_occupancy_ctrl_hyst_flag #(
    .P_VAL_WIDTH (P_WUSED_WIDTH),
    .P_TH_WIDTH  (P_ADR_WIDTH + 1)
  ) u_almost_full (
    .clk    (clk),
    .rst    (rst),
    .val    (wvb_wused),
    .set_th (hwm_thresh),
    .clr_th (lwm_thresh),
    .flag   (almost_full)
  );

endmodule

// File: tb/tb_wvb_occupancy_ctrl.sv
// Directed bench for wvb_occupancy_ctrl at a 16-word buffer, delay 2,
// watermarks 12/4; expected values are hand-derived per step.
module tb_wvb_occupancy_ctrl;

  localparam int AW = 4;
  localparam int WW = 16;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic [AW:0]   hwm_thresh;
  logic [AW:0]   lwm_thresh;
  logic          ovf_clr;
  logic          overflow_sticky;
  logic          almost_full;
  logic [WW-1:0] wvb_wused;
  logic [CW-1:0] ovf_count;

  int n_chk;
  int n_err;

  wvb_occupancy_ctrl_if #(.P_ADR_WIDTH(AW)) bus ();

  wvb_occupancy_ctrl #(
    .P_ADR_WIDTH   (AW),
    .P_WUSED_WIDTH (WW),
    .P_OVF_DELAY   (2),
    .P_CNT_WIDTH   (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .hwm_thresh      (hwm_thresh),
    .lwm_thresh      (lwm_thresh),
    .ovf_clr         (ovf_clr),
    .overflow_sticky (overflow_sticky),
    .almost_full     (almost_full),
    .wvb_wused       (wvb_wused),
    .ovf_count       (ovf_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_burst(input logic [AW-1:0] start, input int n);
    logic [AW-1:0] a;
    a = start;
    repeat (n) begin
      bus.wvb_wr_addr = a;
      bus.wvb_wr_en   = 1'b1;
      tick();
      a = a + 4'd1;
    end
    bus.wvb_wr_en   = 1'b0;
    bus.wvb_wr_addr = a;
  endtask

  task automatic rd(input logic [AW-1:0] stop);
    bus.wvb_rddone   = 1'b1;
    bus.rd_stop_addr = stop;
    tick();
    bus.wvb_rddone   = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst              = 1'b1;
    hwm_thresh       = 5'd12;
    lwm_thresh       = 5'd4;
    ovf_clr          = 1'b0;
    bus.wvb_wr_addr  = '0;
    bus.wvb_wr_en    = 1'b0;
    bus.wvb_rddone   = 1'b0;
    bus.rd_stop_addr = '0;
    bus.hdr_full     = 1'b0;
    tick();
    tick();
    chk("rst_overflow", 32'(bus.overflow), 0);
    chk("rst_sticky", 32'(overflow_sticky), 0);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_wused", 32'(wvb_wused), 0);
    chk("rst_count", 32'(ovf_count), 0);
    rst = 1'b0;
    tick();

    // five words, occupancy visible one cycle after the last write
    wr_burst(4'd0, 5);
    tick();
    chk("wused5", 32'(wvb_wused), 5);
    chk("wused5_af", 32'(almost_full), 0);
    chk("wused5_ovf", 32'(bus.overflow), 0);

    // fill to 16; buf_ovf 3 cycles after the filling write
    wr_burst(4'd5, 11);
    chk("fill_ovf_d0", 32'(bus.overflow), 0);
    tick();
    chk("fill_ovf_d1", 32'(bus.overflow), 0);
    chk("fill_wused16", 32'(wvb_wused), 16);
    tick();
    chk("fill_ovf_d2", 32'(bus.overflow), 0);
    tick();
    chk("fill_ovf_d3", 32'(bus.overflow), 1);
    chk("fill_count", 32'(ovf_count), 1);
    chk("fill_sticky", 32'(overflow_sticky), 1);
    chk("fill_af", 32'(almost_full), 1);

    // write while full is ignored
    bus.wvb_wr_addr = 4'd0;
    bus.wvb_wr_en   = 1'b1;
    tick();
    bus.wvb_wr_en   = 1'b0;
    tick();
    chk("viol_wused", 32'(wvb_wused), 16);

    // recover: read to 9 then to 11
    rd(4'd9);
    tick();
    chk("rec_wused6", 32'(wvb_wused), 6);
    chk("rec_ovf_held", 32'(bus.overflow), 1);
    tick();
    chk("rec_af_hold", 32'(almost_full), 1);
    rd(4'd11);
    tick();
    chk("rec_wused4", 32'(wvb_wused), 4);
    chk("rec_ovf_s2", 32'(bus.overflow), 1);
    tick();
    chk("rec_ovf_rel", 32'(bus.overflow), 0);
    chk("rec_af_clr", 32'(almost_full), 0);

    // pointer wrap
    rd(4'd15);
    tick();
    chk("wrap_empty", 32'(wvb_wused), 0);
    wr_burst(4'd0, 14);
    rd(4'd13);
    tick();
    wr_burst(4'd14, 4);
    tick();
    chk("wrap_wused4", 32'(wvb_wused), 4);
    rd(4'd15);
    tick();
    chk("wrap_wused2", 32'(wvb_wused), 2);

    // full cleared inside DELAY: no overflow
    wr_burst(4'd2, 14);
    rd(4'd1);
    for (int i = 0; i < 4; i++) begin
      chk("abort_ovf", 32'(bus.overflow), 0);
      tick();
    end
    chk("abort_count", 32'(ovf_count), 1);

    // rddone and filling write in the same cycle: clear wins
    wr_burst(4'd0, 1);
    bus.wvb_wr_addr  = 4'd1;
    bus.wvb_wr_en    = 1'b1;
    bus.wvb_rddone   = 1'b1;
    bus.rd_stop_addr = 4'd3;
    tick();
    bus.wvb_wr_en    = 1'b0;
    bus.wvb_rddone   = 1'b0;
    bus.wvb_wr_addr  = 4'd2;
    tick();
    chk("coinc_wused14", 32'(wvb_wused), 14);
    for (int i = 0; i < 4; i++) begin
      chk("coinc_ovf", 32'(bus.overflow), 0);
      tick();
    end

    // sticky clear, then clear coincident with OVF entry
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("sticky_clr", 32'(overflow_sticky), 0);
    wr_burst(4'd2, 2);
    tick();
    tick();
    chk("clr_ovf_d2", 32'(bus.overflow), 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_set_wins", 32'(overflow_sticky), 1);
    chk("clr_count2", 32'(ovf_count), 2);
    chk("clr_ovf", 32'(bus.overflow), 1);

    // asynchronous reset in OVF
    rst = 1'b1;
    #1;
    chk("arst_ovf", 32'(bus.overflow), 0);
    chk("arst_sticky", 32'(overflow_sticky), 0);
    chk("arst_count", 32'(ovf_count), 0);
    chk("arst_wused", 32'(wvb_wused), 0);
    chk("arst_af", 32'(almost_full), 0);
    tick();
    rst = 1'b0;
    bus.wvb_wr_addr = 4'd0;
    tick();

    // header FIFO full passes straight through
    bus.hdr_full = 1'b1;
    #1;
    chk("hdr_ovf", 32'(bus.overflow), 1);
    tick();
    chk("hdr_count", 32'(ovf_count), 0);
    bus.hdr_full = 1'b0;
    #1;
    chk("hdr_ovf_off", 32'(bus.overflow), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
